symbol_playback: RTL

- Read-side counterpart of the symbol storage buffer: drains packed {I[3:0],Q[3:0]} symbols from the 512-entry symbol region (addresses 0..511) in write order.
- Gray-decodes each symbol to signed 64-QAM amplitudes and presents them to the pulse-shaping / DAC path at a paced symbol rate over a valid/ready handshake.
- Tracks buffer fill against the storage write pointer; handles priming, underflow and late-accept conditions.

---
 rtl/symbol_playback.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/symbol_playback.sv
// Symbol playback: drains packed {I,Q} symbols from the storage buffer in write order,
// Gray-decodes them to signed 64-QAM levels and presents them at a paced symbol rate.
module symbol_playback #(
  parameter int SYM_DIV     = 8,
  parameter int START_LEVEL = 16
) (
  input  logic       sym_clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       flush,
  input  logic [9:0] wr_ptr,
  output logic       mem_rd_en,
  output logic [9:0] mem_rd_addr,
  input  logic [7:0] mem_rd_data,
  output logic [3:0] i_level,
  output logic [3:0] q_level,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic [9:0] fill_level,
  output logic       underflow,
  output logic       sym_late
);

  // state   | meaning
  // IDLE    | not playing; waits for enable and a primed buffer
  // WAIT    | running; waits for the next symbol tick
  // FETCH   | memory read strobe issued at rd_ptr
  // CAPTURE | read data returns; decode, register, advance rd_ptr
  // HOLD    | symbol presented until accepted downstream
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WAIT    = 3'd1;
  localparam logic [2:0] FETCH   = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] HOLD    = 3'd4;

  localparam logic [7:0] DIV_LOAD   = 8'(SYM_DIV - 1);
  localparam logic [9:0] START_FILL = 10'(START_LEVEL);

  logic [2:0] state_q, state_d;
  logic [9:0] rd_ptr_q, rd_ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  logic [3:0] i_q, i_d;
  logic [3:0] q_q, q_d;
  logic       underflow_q, underflow_d;
  logic       late_q, late_d;
  logic [9:0] fill_q;
  logic [9:0] fill;
  logic       tick;
  logic       mid_symbol;
  logic       unused_nibble_msbs;

  function automatic logic [3:0] gray_level(input logic [2:0] g);
    case (g)
      3'b000:  gray_level = 4'b1001;
      3'b001:  gray_level = 4'b1011;
      3'b011:  gray_level = 4'b1101;
      3'b010:  gray_level = 4'b1111;
      3'b110:  gray_level = 4'b0001;
      3'b111:  gray_level = 4'b0011;
      3'b101:  gray_level = 4'b0101;
      default: gray_level = 4'b0111;
    endcase
  endfunction

  assign unused_nibble_msbs = mem_rd_data[7] ^ mem_rd_data[3];

  assign fill       = (wr_ptr >= rd_ptr_q) ? (wr_ptr - rd_ptr_q)
                                           : (wr_ptr + 10'd512 - rd_ptr_q);
  assign tick       = (state_q != IDLE) && (cnt_q == 8'd0);
  assign mid_symbol = (state_q == FETCH) || (state_q == CAPTURE) || (state_q == HOLD);

  // The counter sits loaded in IDLE, so leaving IDLE starts a full SYM_DIV period.
  always_comb begin
    cnt_d = cnt_q - 8'd1;
    if (state_q == IDLE || tick) cnt_d = DIV_LOAD;
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    valid_d     = valid_q;
    i_d         = i_q;
    q_d         = q_q;
    underflow_d = underflow_q;
    late_d      = late_q;

    if (tick && mid_symbol) late_d = 1'b1;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (enable && fill >= START_FILL) state_d = WAIT;
      end
      WAIT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (tick) begin
          if (fill == 10'd0) begin
            underflow_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: state_d = CAPTURE;
      CAPTURE: begin
        i_d      = gray_level(mem_rd_data[6:4]);
        q_d      = gray_level(mem_rd_data[2:0]);
        valid_d  = 1'b1;
        rd_ptr_d = (rd_ptr_q == 10'd511) ? 10'd0 : rd_ptr_q + 10'd1;
        state_d  = HOLD;
      end
      HOLD: begin
        if (valid_q && sym_ready) begin
          valid_d = 1'b0;
          state_d = enable ? WAIT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides everything, including a same-cycle accept.
    if (flush) begin
      rd_ptr_d    = wr_ptr;
      valid_d     = 1'b0;
      state_d     = IDLE;
      underflow_d = 1'b0;
      late_d      = 1'b0;
    end
  end

  always_ff @(posedge sym_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_ptr_q    <= 10'd0;
      cnt_q       <= DIV_LOAD;
      valid_q     <= 1'b0;
      i_q         <= 4'd0;
      q_q         <= 4'd0;
      underflow_q <= 1'b0;
      late_q      <= 1'b0;
      fill_q      <= 10'd0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      i_q         <= i_d;
      q_q         <= q_d;
      underflow_q <= underflow_d;
      late_q      <= late_d;
      fill_q      <= fill;
    end
  end

  assign mem_rd_en   = (state_q == FETCH);
  assign mem_rd_addr = mem_rd_en ? rd_ptr_q : 10'd0;
  assign i_level     = i_q;
  assign q_level     = q_q;
  assign sym_valid   = valid_q;
  assign fill_level  = fill_q;
  assign underflow   = underflow_q;
  assign sym_late    = late_q;

endmodule
